// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the two TX requesters, the arbiter and the UART serializer.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8
);
  logic                    req0_valid;
  logic [DATA_WIDTH-1:0]   req0_data;
  logic                    req0_ready;
  logic                    req1_valid;
  logic [2*DATA_WIDTH-1:0] req1_data;
  logic                    req1_ready;
  logic [DATA_WIDTH-1:0]   tx_p_data;
  logic                    tx_data_valid;
  logic                    tx_busy;
  logic                    ctrl_busy;

  // master: requesters plus transmitter; slave: the arbiter itself
  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    input  req0_ready, req1_ready, tx_p_data, tx_data_valid, ctrl_busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, tx_busy,
    output req0_ready, req1_ready, tx_p_data, tx_data_valid, ctrl_busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serializer between a 1-byte and a 2-byte (low byte first) requester.
// Define UART_TX_ARB_RR_EN for round-robin arbitration; default is fixed priority to REQ0.
//
// state   | meaning
// IDLE    | waiting for a request while the transmitter is idle
// ISSUE   | data-valid pulse for the current byte
// WAIT_HI | waiting for tx_busy to rise, re-issue after BUSY_TIMEOUT cycles
// WAIT_LO | waiting for tx_busy to fall, then next byte or back to IDLE
module uart_tx_arbiter #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  state_t                  state;
  logic [2*DATA_WIDTH-1:0] word;
  logic                    two_byte;
  logic                    byte_idx;
  logic [3:0]              tmo_cnt;
  logic                    start;
  logic                    grant0;

  assign start = (state == IDLE) && !bus.tx_busy && (bus.req0_valid || bus.req1_valid);

`ifdef UART_TX_ARB_RR_EN
  // last_req1 remembers who won last; reset value lets REQ0 win first
  logic last_req1;

  assign grant0 = bus.req0_valid && (!bus.req1_valid || last_req1);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_req1 <= 1'b1;
    end else if (start) begin
      last_req1 <= !grant0;
    end
  end
`else
  assign grant0 = bus.req0_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      word              <= '0;
      two_byte          <= 1'b0;
      byte_idx          <= 1'b0;
      tmo_cnt           <= '0;
      bus.req0_ready    <= 1'b0;
      bus.req1_ready    <= 1'b0;
      bus.tx_p_data     <= '0;
      bus.tx_data_valid <= 1'b0;
      bus.ctrl_busy     <= 1'b0;
    end else begin
      bus.req0_ready    <= 1'b0;
      bus.req1_ready    <= 1'b0;
      bus.tx_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state             <= ISSUE;
            byte_idx          <= 1'b0;
            bus.tx_data_valid <= 1'b1;
            bus.ctrl_busy     <= 1'b1;
            if (grant0) begin
              word           <= {{DATA_WIDTH{1'b0}}, bus.req0_data};
              two_byte       <= 1'b0;
              bus.req0_ready <= 1'b1;
              bus.tx_p_data  <= bus.req0_data;
            end else begin
              word           <= bus.req1_data;
              two_byte       <= 1'b1;
              bus.req1_ready <= 1'b1;
              bus.tx_p_data  <= bus.req1_data[DATA_WIDTH-1:0];
            end
          end
        end
        ISSUE: begin
          tmo_cnt <= '0;
          state   <= WAIT_HI;
        end
        WAIT_HI: begin
          if (bus.tx_busy) begin
            state <= WAIT_LO;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
            // transmitter missed the pulse: resend the same byte
            if (tmo_cnt + 4'd1 == 4'(BUSY_TIMEOUT)) begin
              state             <= ISSUE;
              bus.tx_data_valid <= 1'b1;
            end
          end
        end
        WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (two_byte && !byte_idx) begin
              byte_idx          <= 1'b1;
              state             <= ISSUE;
              bus.tx_data_valid <= 1'b1;
              bus.tx_p_data     <= word[2*DATA_WIDTH-1:DATA_WIDTH];
            end else begin
              state         <= IDLE;
              bus.ctrl_busy <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  // a requester may only withdraw VALID once its READY pulse has been seen
  a_req0_hold: assert property (@(posedge clk) disable iff (rst)
    $fell(bus.req0_valid) |-> (bus.req0_ready || $past(bus.req0_ready)));
  a_req1_hold: assert property (@(posedge clk) disable iff (rst)
    $fell(bus.req1_valid) |-> (bus.req1_ready || $past(bus.req1_ready)));
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: cycle-by-cycle vector table plus corner-case sequences.
module tb_uart_tx_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  uart_tx_arbiter_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_arbiter #(.DATA_WIDTH(8), .BUSY_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [7:0]  d0;
    logic        v1;
    logic [15:0] d1;
    logic        busy;
    logic        r0;
    logic        r1;
    logic        dv;
    logic [7:0]  data;
    logic        cb;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string nm, input logic r0, input logic r1, input logic dv,
                       input logic [7:0] d, input logic cb);
    logic [11:0] act;
    logic [11:0] exp;
    act = {bus.req0_ready, bus.req1_ready, bus.tx_data_valid, bus.tx_p_data, bus.ctrl_busy};
    exp = {r0, r1, dv, d, cb};
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got r0=%b r1=%b dv=%b data=%h cbusy=%b, want r0=%b r1=%b dv=%b data=%h cbusy=%b",
               nm, act[11], act[10], act[9], act[8:1], act[0], r0, r1, dv, d, cb);
    end
  endtask

  task automatic step(input logic b, input string nm, input logic r0, input logic r1,
                      input logic dv, input logic [7:0] d, input logic cb);
    bus.tx_busy = b;
    @(posedge clk);
    #1;
    check(nm, r0, r1, dv, d, cb);
  endtask

  // from an ISSUE cycle: busy rises one cycle later, held one cycle, then falls
  task automatic tail(input string nm, input logic [7:0] d, input logic more, input logic [7:0] nd);
    step(L, {nm, "_whi"}, L, L, L, d, H);
    step(H, {nm, "_wlo"}, L, L, L, d, H);
    if (more) step(L, {nm, "_next"}, L, L, H, nd, H);
    else      step(L, {nm, "_done"}, L, L, L, d, L);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = '0;
    bus.tx_busy    = 1'b0;

    //           rst v0 d0     v1 d1         busy  r0 r1 dv data   cb
    vecs[0]  = '{H, L, 8'h00, L, 16'h0000, L,    L, L, L, 8'h00, L}; // reset
    vecs[1]  = '{L, H, 8'hA5, L, 16'h0000, L,    H, L, H, 8'hA5, H}; // single byte grant
    vecs[2]  = '{L, L, 8'hA5, L, 16'h0000, L,    L, L, L, 8'hA5, H};
    vecs[3]  = '{L, L, 8'hA5, L, 16'h0000, H,    L, L, L, 8'hA5, H};
    vecs[4]  = '{L, L, 8'hA5, L, 16'h0000, H,    L, L, L, 8'hA5, H};
    vecs[5]  = '{L, L, 8'hA5, L, 16'h0000, L,    L, L, L, 8'hA5, L};
    vecs[6]  = '{L, L, 8'hA5, L, 16'h0000, L,    L, L, L, 8'hA5, L};
    vecs[7]  = '{L, L, 8'h00, H, 16'h1234, L,    L, H, H, 8'h34, H}; // two byte, low first
    vecs[8]  = '{L, L, 8'h00, L, 16'h1234, L,    L, L, L, 8'h34, H};
    vecs[9]  = '{L, L, 8'h00, L, 16'h1234, H,    L, L, L, 8'h34, H};
    vecs[10] = '{L, L, 8'h00, L, 16'h1234, L,    L, L, H, 8'h12, H}; // high byte 1 cycle after fall
    vecs[11] = '{L, L, 8'h00, L, 16'h1234, L,    L, L, L, 8'h12, H};
    vecs[12] = '{L, L, 8'h00, L, 16'h1234, H,    L, L, L, 8'h12, H};
    vecs[13] = '{L, L, 8'h00, L, 16'h1234, L,    L, L, L, 8'h12, L};
    vecs[14] = '{L, H, 8'h5A, L, 16'h0000, H,    L, L, L, 8'h12, L}; // busy in IDLE blocks grant
    vecs[15] = '{L, H, 8'h5A, L, 16'h0000, H,    L, L, L, 8'h12, L};
    vecs[16] = '{L, H, 8'h5A, L, 16'h0000, L,    H, L, H, 8'h5A, H};
    vecs[17] = '{L, L, 8'h5A, L, 16'h0000, H,    L, L, L, 8'h5A, H};
    vecs[18] = '{L, L, 8'h5A, L, 16'h0000, H,    L, L, L, 8'h5A, H};
    vecs[19] = '{L, L, 8'h5A, L, 16'h0000, L,    L, L, L, 8'h5A, L};
    vecs[20] = '{L, L, 8'h00, H, 16'hC3D2, L,    L, H, H, 8'hD2, H}; // reset mid-frame
    vecs[21] = '{L, L, 8'h00, L, 16'hC3D2, L,    L, L, L, 8'hD2, H};
    vecs[22] = '{L, L, 8'h00, L, 16'hC3D2, H,    L, L, L, 8'hD2, H};
    vecs[23] = '{H, L, 8'h00, L, 16'hC3D2, H,    L, L, L, 8'h00, L};
    vecs[24] = '{L, L, 8'h00, L, 16'hC3D2, L,    L, L, L, 8'h00, L};
    vecs[25] = '{L, L, 8'h00, L, 16'hC3D2, L,    L, L, L, 8'h00, L};

    for (int i = 0; i < 26; i++) begin
      rst            = vecs[i].rst;
      bus.req0_valid = vecs[i].v0;
      bus.req0_data  = vecs[i].d0;
      bus.req1_valid = vecs[i].v1;
      bus.req1_data  = vecs[i].d1;
      step(vecs[i].busy, $sformatf("vec[%0d]", i),
           vecs[i].r0, vecs[i].r1, vecs[i].dv, vecs[i].data, vecs[i].cb);
    end

    // contention straight out of reset
    rst = 1'b1;
    step(L, "cont_reset", L, L, L, 8'h00, L);
    rst = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h11;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 16'hBEEF;
    step(L, "cont_g0", H, L, H, 8'h11, H);
`ifdef UART_TX_ARB_RR_EN
    tail("rr_a", 8'h11, L, 8'h00);
    step(L, "rr_g1", L, H, H, 8'hEF, H);
    tail("rr_b", 8'hEF, H, 8'hBE);
    tail("rr_c", 8'hBE, L, 8'h00);
    step(L, "rr_g2", H, L, H, 8'h11, H);
    bus.req0_valid = 1'b0;
    tail("rr_d", 8'h11, L, 8'h00);
    step(L, "rr_g3", L, H, H, 8'hEF, H);
    bus.req1_valid = 1'b0;
    tail("rr_e", 8'hEF, H, 8'hBE);
    tail("rr_f", 8'hBE, L, 8'h00);
`else
    bus.req0_valid = 1'b0;
    tail("fp_a", 8'h11, L, 8'h00);
    step(L, "fp_g1", L, H, H, 8'hEF, H);
    bus.req1_valid = 1'b0;
    tail("fp_b", 8'hEF, H, 8'hBE);
    tail("fp_c", 8'hBE, L, 8'h00);
`endif

    // transmitter ignores the first pulse: re-issue 4 cycles after WAIT_HI entry
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h77;
    step(L, "tmo_grant", H, L, H, 8'h77, H);
    bus.req0_valid = 1'b0;
    step(L, "tmo_whi0", L, L, L, 8'h77, H);
    for (int i = 1; i <= 4; i++) begin
      step(L, $sformatf("tmo_whi%0d", i), L, L, (i == 4), 8'h77, H);
    end
    tail("tmo_end", 8'h77, L, 8'h00);
    step(L, "tmo_idle", L, L, L, 8'h77, L);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
